// File: rtl/wgt_pkg.sv
// Shared types and per-layer sizing for the weight SRAM streamer.
package wgt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WGT_WIDTH = 16;
    localparam int WGT_DEPTH = 10;

    localparam int L0_WIDTH = 16;
    localparam int L0_DEPTH = 10;
    localparam int L1_WIDTH = 16;
    localparam int L1_DEPTH = 24;

endpackage

// File: rtl/wgt_sram_core.sv
// Single-port-write, registered-read weight array; no reset so it maps to block RAM.
module wgt_sram_core #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-first: a same-cycle write is only visible to later reads.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
    end

endmodule

// File: rtl/wgt_sram_stream.sv
// Weight store with random port, sequential load port and wrapping burst reader.
module wgt_sram_stream
    import wgt_pkg::*;
#(
    parameter int WIDTH = WGT_WIDTH,
    parameter int DEPTH = WGT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_clr,
    output logic             ld_full,
    input  logic             rd_start,
    input  logic [AW-1:0]    rd_base,
    input  logic [LW-1:0]    rd_len,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             q_last,
    output logic             busy,
    output logic             err
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    ld_ptr;
    logic [LW-1:0]    cnt;
    logic             q_ok;
    logic [WIDTH-1:0] core_q;

    logic             idle;
    logic             in_burst;
    logic             ld_act;
    logic             ld_ok;
    logic             addr_ok;
    logic             we_ok;
    logic             rd_ok;
    logic             bad;
    logic             wen;
    logic             ren;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] wdata;

    assign idle     = (state == IDLE);
    assign in_burst = (state == BURST);
    assign ld_act   = ld_valid && !ld_clr;
    assign ld_ok    = ld_act && !ld_full;
    assign addr_ok  = {1'b0, addr} < DEPTH_L;
    assign we_ok    = we && idle && addr_ok && !ld_act;
    assign rd_ok    = rd_start && idle && (rd_len != '0)
                    && (rd_len <= DEPTH_L)
                    && ({1'b0, rd_base} < DEPTH_L);
    assign bad      = (ld_act && ld_full)
                    || (we && !we_ok)
                    || (rd_start && idle && !rd_ok);

    // The load port owns the write port whenever it is active.
    assign wen   = ld_ok || we_ok;
    assign waddr = ld_ok ? ld_ptr : addr;
    assign wdata = ld_ok ? ld_data : data;
    assign ren   = in_burst || (idle && !we && addr_ok);
    assign raddr = in_burst ? rd_ptr : addr;

    // q_ok masks the unreset RAM output until a real read lands.
    assign q = q_ok ? core_q : '0;

    wgt_sram_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .ren   (ren),
        .raddr (raddr),
        .rdata (core_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            cnt     <= '0;
            ld_ptr  <= '0;
            ld_full <= 1'b0;
            q_ok    <= 1'b0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err     <= bad;
            q_valid <= in_burst;
            q_last  <= in_burst && (cnt == LW'(1));
            if (ren) q_ok <= 1'b1;

            if (ld_clr) begin
                ld_ptr  <= '0;
                ld_full <= 1'b0;
            end else if (ld_ok) begin
                if (ld_ptr == LAST_A) begin
                    ld_ptr  <= '0;
                    ld_full <= 1'b1;
                end else begin
                    ld_ptr <= ld_ptr + AW'(1);
                end
            end

            unique case (state)
                IDLE: begin
                    if (rd_ok) begin
                        state  <= BURST;
                        busy   <= 1'b1;
                        rd_ptr <= rd_base;
                        cnt    <= rd_len;
                    end
                end
                BURST: begin
                    rd_ptr <= (rd_ptr == LAST_A) ? '0 : rd_ptr + AW'(1);
                    cnt    <= cnt - LW'(1);
                    if (cnt == LW'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wgt_sram_stream.sv
// Directed scenario bench for wgt_sram_stream (WIDTH 16, DEPTH 10).
module tb_wgt_sram_stream;

    localparam int WIDTH = 16;
    localparam int DEPTH = 10;
    localparam int AW = 4;
    localparam int LW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_clr;
    logic             ld_full;
    logic             rd_start;
    logic [AW-1:0]    rd_base;
    logic [LW-1:0]    rd_len;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_last;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wgt_sram_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr     (addr),
        .data     (data),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_clr   (ld_clr),
        .ld_full  (ld_full),
        .rd_start (rd_start),
        .rd_base  (rd_base),
        .rd_len   (rd_len),
        .q        (q),
        .q_valid  (q_valid),
        .q_last   (q_last),
        .busy     (busy),
        .err      (err)
    );

    task automatic idle_inputs();
        we       = 1'b0;
        addr     = '0;
        data     = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_clr   = 1'b0;
        rd_start = 1'b0;
        rd_base  = '0;
        rd_len   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (q !== 16'h0) begin
            errors++; $display("FAIL reset_q got %h exp 0000", q);
        end
        checks++;
        if ({q_valid, q_last, busy, ld_full, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {q_valid, q_last, busy, ld_full, err});
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        @(negedge clk);
        we = 1'b1; addr = 4'd3; data = 16'h1234;
        @(negedge clk);
        addr = 4'd9; data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL rand_wr_err got %b exp 0", err);
        end
        we = 1'b0; addr = 4'd3;
        @(negedge clk);
        checks++;
        if (q !== 16'h1234 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_rd3 got %h/%b exp 1234/0", q, q_valid);
        end
        addr = 4'd9;
        @(negedge clk);
        checks++;
        if (q !== 16'hBEEF) begin
            errors++; $display("FAIL rand_rd9 got %h exp beef", q);
        end
    endtask

    task automatic test_load();
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'h0100 + 16'(i);
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if (ld_full !== 1'b0) begin
                    errors++; $display("FAIL ld_full_early got %b exp 0", ld_full);
                end
            end
        end
        checks++;
        if (ld_full !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL ld_full_set got %b/%b exp 1/0", ld_full, err);
        end
        ld_data = 16'hDEAD;
        addr = 4'd0;
        @(negedge clk);
        ld_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL ld_overflow_err got %b exp 1", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL ld_err_pulse got %b exp 0", err);
        end
        @(negedge clk);
        checks++;
        if (q !== 16'h0100) begin
            errors++; $display("FAIL ld_mem0 got %h exp 0100", q);
        end
    endtask

    task automatic test_wrap_burst();
        logic [15:0] exp_w [4];
        exp_w = '{16'h0108, 16'h0109, 16'h0100, 16'h0101};
        rd_start = 1'b1; rd_base = 4'd8; rd_len = 5'd4;
        @(negedge clk);
        rd_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_start got busy %b qv %b exp 1 0", busy, q_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (q_valid !== 1'b1 || q !== exp_w[k] || q_last !== (k == 3)) begin
                errors++;
                $display("FAIL wrap_w%0d got %h v%b l%b exp %h v1 l%b",
                         k, q, q_valid, q_last, exp_w[k], k == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (q_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got qv %b busy %b exp 0 0", q_valid, busy);
        end
    endtask

    task automatic test_illegal();
        logic [AW-1:0] bases [3];
        logic [LW-1:0] lens [3];
        bases = '{4'd0, 4'd0, 4'd10};
        lens  = '{5'd0, 5'd11, 5'd4};
        for (int i = 0; i < 3; i++) begin
            rd_start = 1'b1; rd_base = bases[i]; rd_len = lens[i];
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_rd%0d got err %b busy %b exp 1 0",
                         i, err, busy);
            end
        end
        rd_start = 1'b0;
        we = 1'b1; addr = 4'd12; data = 16'hFFFF;
        @(negedge clk);
        we = 1'b0; addr = 4'd2;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL illegal_addr got %b exp 1", err);
        end
        @(negedge clk);
        checks++;
        if (q !== 16'h0102 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_mem got %h e%b b%b exp 0102 e0 b0",
                     q, err, busy);
        end
    endtask

    task automatic test_contention();
        logic [15:0] exp_w [4];
        exp_w = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
        rd_start = 1'b1; rd_base = 4'd0; rd_len = 5'd4;
        @(negedge clk);
        rd_start = 1'b0;
        we = 1'b1; addr = 4'd5; data = 16'hAAAA;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || q !== exp_w[0] || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL cont_we_burst got e%b %h v%b exp e1 0100 v1",
                     err, q, q_valid);
        end
        addr = 4'd6; data = 16'hBBBB;
        ld_valid = 1'b1; ld_data = 16'h5555;
        @(negedge clk);
        we = 1'b0; ld_valid = 1'b0; addr = 4'd0;
        checks++;
        if (err !== 1'b1 || q !== exp_w[1]) begin
            errors++;
            $display("FAIL cont_ld_we got e%b %h exp e1 0101", err, q);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || q !== exp_w[2]) begin
            errors++;
            $display("FAIL cont_w2 got e%b %h exp e0 0102", err, q);
        end
        @(negedge clk);
        checks++;
        if (q !== exp_w[3] || q_last !== 1'b1) begin
            errors++;
            $display("FAIL cont_w3 got %h l%b exp 0103 l1", q, q_last);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL cont_end got b%b v%b exp 0 0", busy, q_valid);
        end
        @(negedge clk);
        addr = 4'd5;
        checks++;
        if (q !== 16'h5555) begin
            errors++; $display("FAIL cont_ld_mem0 got %h exp 5555", q);
        end
        @(negedge clk);
        addr = 4'd6;
        checks++;
        if (q !== 16'h0105) begin
            errors++; $display("FAIL cont_mem5 got %h exp 0105", q);
        end
        @(negedge clk);
        checks++;
        if (q !== 16'h0106) begin
            errors++; $display("FAIL cont_mem6 got %h exp 0106", q);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] exp_w [3];
        exp_w = '{16'h0102, 16'h0103, 16'h0104};
        rd_start = 1'b1; rd_base = 4'd0; rd_len = 5'd6;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        checks++;
        if (q !== 16'h5555 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_w0 got %h v%b exp 5555 v1", q, q_valid);
        end
        @(negedge clk);
        checks++;
        if (q !== 16'h0101 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_w1 got %h v%b exp 0101 v1", q, q_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (q_valid !== 1'b0 || busy !== 1'b0 || q_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got v%b b%b l%b exp 0 0 0",
                     q_valid, busy, q_last);
        end
        rd_start = 1'b1; rd_base = 4'd2; rd_len = 5'd3;
        @(negedge clk);
        rd_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_restart got %b exp 1", busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (q_valid !== 1'b1 || q !== exp_w[k] || q_last !== (k == 2)) begin
                errors++;
                $display("FAIL mid_new_w%0d got %h v%b l%b exp %h v1 l%b",
                         k, q, q_valid, q_last, exp_w[k], k == 2);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_new_end got b%b v%b exp 0 0", busy, q_valid);
        end
    endtask

    task automatic test_back_to_back();
        rd_start = 1'b1; rd_base = 4'd9; rd_len = 5'd2;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        checks++;
        if (q !== 16'h0109 || q_valid !== 1'b1 || q_last !== 1'b0) begin
            errors++;
            $display("FAIL b2b_w0 got %h v%b l%b exp 0109 v1 l0",
                     q, q_valid, q_last);
        end
        @(negedge clk);
        checks++;
        if (q !== 16'h5555 || q_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_w1 got %h l%b exp 5555 l1", q, q_last);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got b%b v%b exp 0 0", busy, q_valid);
        end
        rd_start = 1'b1; rd_base = 4'd1; rd_len = 5'd1;
        @(negedge clk);
        rd_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept got %b exp 1", busy);
        end
        @(negedge clk);
        checks++;
        if (q !== 16'h0101 || q_valid !== 1'b1 || q_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_single got %h v%b l%b exp 0101 v1 l1",
                     q, q_valid, q_last);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got b%b v%b exp 0 0", busy, q_valid);
        end
    endtask

    initial begin
        test_reset();
        test_random();
        test_load();
        test_wrap_burst();
        test_illegal();
        test_contention();
        test_reset_mid_burst();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
